// File: rtl/rv_mc_ctrl.sv
// rv_mc_ctrl: multi-cycle RV32I control FSM.
//   Sequences FETCH -> DECODE -> execute state -> (WB) -> FETCH and drives a
//   16-bit registered control word for the datapath. Memory waits are bounded
//   by a saturating wait counter; a timeout parks the FSM in HALT with bus_err.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           leave IDLE
//   instr           instruction register contents (opcode in [6:0])
//   branch_taken    ALU compare result for BRANCH
//   mem_ready       memory completion strobe
//   ctrl[15:0]      [0] pc_we [2:1] pc_sel [3] ir_we [4] reg_we [5] alu_src_imm
//                   [7:6] wb_sel [8] auipc [9] mem_req [10] mem_we [11] addr_data
//   state[3:0]      current state encoding
//   busy            high outside IDLE and HALT
//   illegal         sticky illegal-opcode flag
//   bus_err         sticky memory-timeout flag
//   cycle_cnt,
//   instret         (only with RV_MC_CTRL_PERF_EN) busy cycles / retired instrs
//
// Optional feature macro: RV_MC_CTRL_PERF_EN
//
// Timing of the registered control word: ctrl is loaded on the same edge as
// the state it belongs to, so anything it depends on (branch_taken, the
// memory-completion event) is sampled in the cycle before that state. The
// FETCH completion strobe (ir_we) therefore shows up in DECODE, and a LOAD
// spends one extra LOAD cycle after mem_ready carrying reg_we / wb_sel=mem.
module rv_mc_ctrl #(
  parameter int unsigned MEM_TIMEOUT  = 15,
  parameter int unsigned TMO_W        = 8,
  parameter int unsigned ILLEGAL_HALT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic [15:0] ctrl,
  output logic [3:0]  state,
  output logic        busy,
  output logic        illegal,
  output logic        bus_err
`ifdef RV_MC_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret
`endif
);

  localparam int unsigned CW = TMO_W + 1;

  // control word bit positions
  localparam int unsigned B_PC_WE     = 0;
  localparam int unsigned B_PC_SEL    = 1;
  localparam int unsigned B_IR_WE     = 3;
  localparam int unsigned B_REG_WE    = 4;
  localparam int unsigned B_ALU_IMM   = 5;
  localparam int unsigned B_WB_SEL    = 6;
  localparam int unsigned B_AUIPC     = 8;
  localparam int unsigned B_MEM_REQ   = 9;
  localparam int unsigned B_MEM_WE    = 10;
  localparam int unsigned B_ADDR_DATA = 11;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EX_IMM = 4'd3,
    S_EX_REG = 4'd4,
    S_JAL    = 4'd5,
    S_JALR   = 4'd6,
    S_LUI    = 4'd7,
    S_AUIPC  = 4'd8,
    S_LOAD   = 4'd9,
    S_STORE  = 4'd10,
    S_BRANCH = 4'd11,
    S_WB     = 4'd12,
    S_HALT   = 4'd15
  } state_t;

  state_t           st_q;
  state_t           nxt;
  state_t           dec_st;
  logic             ld_done;
  logic [TMO_W-1:0] wait_cnt;
  logic [CW-1:0]    cnt_inc;
  logic             waiting;
  logic             at_limit;
  logic             timeout;
  logic             dec_ill;
  logic             ld_fin;
  logic             unused_instr;

  // opcode decode; S_IDLE marks "no legal opcode"
  function automatic state_t dec_op(input logic [6:0] op);
    state_t r;
    r = S_IDLE;
    case (op)
      7'b0010011: r = S_EX_IMM;
      7'b0110011: r = S_EX_REG;
      7'b1101111: r = S_JAL;
      7'b1100111: r = S_JALR;
      7'b0110111: r = S_LUI;
      7'b0010111: r = S_AUIPC;
      7'b0000011: r = S_LOAD;
      7'b0100011: r = S_STORE;
      7'b1100011: r = S_BRANCH;
      default:    r = S_IDLE;
    endcase
    return r;
  endfunction

  // next-state rules
  function automatic state_t next_of(input state_t s, input logic go,
                                     input logic rdy, input logic tmo,
                                     input logic ldd, input logic ill,
                                     input state_t dst);
    state_t r;
    r = s;
    case (s)
      S_IDLE:   r = go ? S_FETCH : S_IDLE;
      S_FETCH:  r = rdy ? S_DECODE : (tmo ? S_HALT : S_FETCH);
      S_STORE:  r = rdy ? S_WB : (tmo ? S_HALT : S_STORE);
      S_LOAD:   r = ldd ? S_WB : (tmo ? S_HALT : S_LOAD);
      S_DECODE: r = ill ? ((ILLEGAL_HALT != 0) ? S_HALT : S_WB) : dst;
      S_EX_IMM, S_EX_REG, S_LUI, S_AUIPC: r = S_WB;
      S_JAL, S_JALR, S_BRANCH, S_WB:      r = S_FETCH;
      S_HALT:   r = S_HALT;
      default:  r = S_IDLE;
    endcase
    return r;
  endfunction

  // control word belonging to a state
  function automatic logic [15:0] ctrl_of(input state_t s, input logic taken,
                                          input logic fin);
    logic [15:0] c;
    c = '0;
    case (s)
      S_FETCH:  c[B_MEM_REQ] = 1'b1;
      S_DECODE: c[B_IR_WE] = 1'b1;
      S_EX_IMM: begin
        c[B_REG_WE]  = 1'b1;
        c[B_ALU_IMM] = 1'b1;
      end
      S_EX_REG: c[B_REG_WE] = 1'b1;
      S_LUI: begin
        c[B_REG_WE]        = 1'b1;
        c[B_WB_SEL +: 2]   = 2'b11;
      end
      S_AUIPC: begin
        c[B_REG_WE]  = 1'b1;
        c[B_ALU_IMM] = 1'b1;
        c[B_AUIPC]   = 1'b1;
      end
      S_JAL, S_JALR: begin
        c[B_REG_WE]      = 1'b1;
        c[B_WB_SEL +: 2] = 2'b10;
        c[B_PC_WE]       = 1'b1;
        c[B_PC_SEL +: 2] = 2'b10;
      end
      S_LOAD: begin
        if (fin) begin
          c[B_REG_WE]      = 1'b1;
          c[B_WB_SEL +: 2] = 2'b01;
        end else begin
          c[B_MEM_REQ]   = 1'b1;
          c[B_ADDR_DATA] = 1'b1;
        end
      end
      S_STORE: begin
        c[B_MEM_REQ]   = 1'b1;
        c[B_MEM_WE]    = 1'b1;
        c[B_ADDR_DATA] = 1'b1;
      end
      S_BRANCH: begin
        c[B_PC_WE]       = 1'b1;
        c[B_PC_SEL +: 2] = taken ? 2'b01 : 2'b00;
      end
      S_WB:     c[B_PC_WE] = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  // a cycle spent waiting on memory; the LOAD completion cycle is not one
  assign waiting  = (st_q == S_FETCH) || (st_q == S_STORE) ||
                    ((st_q == S_LOAD) && !ld_done);
  assign cnt_inc  = {1'b0, wait_cnt} + CW'(1);
  // ready in the cycle the counter would reach the limit still wins
  assign at_limit = cnt_inc >= CW'(MEM_TIMEOUT);
  assign timeout  = waiting && !mem_ready && at_limit;
  assign dec_st   = dec_op(instr[6:0]);
  assign dec_ill  = (st_q == S_DECODE) && (dec_st == S_IDLE);
  assign ld_fin   = (st_q == S_LOAD) && !ld_done && mem_ready;
  assign nxt      = next_of(st_q, start, mem_ready, timeout, ld_done, dec_ill, dec_st);
  assign state    = st_q;
  assign unused_instr = ^instr[31:7];

  // FSM state, registered outputs and wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= S_IDLE;
      ctrl     <= '0;
      busy     <= 1'b0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
      wait_cnt <= '0;
      ld_done  <= 1'b0;
    end else begin
      st_q    <= nxt;
      ctrl    <= ctrl_of(nxt, branch_taken, ld_fin);
      busy    <= (nxt != S_IDLE) && (nxt != S_HALT);
      ld_done <= ld_fin;
      if (dec_ill) illegal <= 1'b1;
      if (timeout) bus_err <= 1'b1;
      if (((nxt == S_FETCH) || (nxt == S_LOAD) || (nxt == S_STORE)) && (nxt != st_q))
        wait_cnt <= '0;
      else if (waiting && !mem_ready && (wait_cnt != '1))
        wait_cnt <= wait_cnt + TMO_W'(1);
    end
  end

`ifdef RV_MC_CTRL_PERF_EN
  // performance counters, free-running modulo 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
      instret   <= '0;
    end else begin
      if (busy)          cycle_cnt <= cycle_cnt + 32'd1;
      if (ctrl[B_PC_WE]) instret   <= instret + 32'd1;
    end
  end
`endif

endmodule
